// File: rtl/perf_event_sequencer.sv
// Performance-event counter bank with periodic/manual snapshot and a single
// valid/ready stream that replays the snapshot one counter per entry.
module perf_event_sequencer #(
  parameter int NUM_EVENTS = 8,
  parameter int CNT_WIDTH  = 32,
  parameter int INTERVAL   = 1024,
  parameter int IDW        = $clog2(NUM_EVENTS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [NUM_EVENTS-1:0] inc,
  input  logic                  clear,
  input  logic                  dump_req,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [IDW-1:0]        out_id,
  output logic [CNT_WIDTH-1:0]  out_count,
  output logic                  out_last,
  output logic                  busy,
  output logic [7:0]            dropped,
  output logic [63:0]           cycle_cnt
);

  localparam int TW = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
  localparam logic [IDW-1:0] LAST_IDX  = IDW'(NUM_EVENTS - 1);
  localparam logic [TW-1:0]  TIMER_TOP = TW'(INTERVAL - 1);

  typedef enum logic {IDLE, DUMP} state_t;

  state_t               state, nextState;
  logic [CNT_WIDTH-1:0] cnt    [NUM_EVENTS];
  logic [CNT_WIDTH-1:0] shadow [NUM_EVENTS];
  logic [IDW-1:0]       idx;
  logic [TW-1:0]        timer;
  logic                 pending;
  logic                 autoTrig, trigger, dumping, isLast, accept, startDump;

  function automatic logic [7:0] satInc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_comb begin
    dumping   = (state == DUMP);
    isLast    = dumping && (idx == LAST_IDX);
    accept    = dumping && out_ready;
    autoTrig  = en && (timer == TIMER_TOP);
    trigger   = dump_req || autoTrig;
    nextState = state;
    startDump = 1'b0;
    case (state)
      IDLE: begin
        if (trigger || pending) begin
          nextState = DUMP;
          startDump = 1'b1;
        end
      end
      DUMP: begin
        if (accept && isLast) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nextState;
  end

  // Sequencing control: entry index, merged-trigger bookkeeping, timers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx       <= '0;
      pending   <= 1'b0;
      dropped   <= '0;
      timer     <= '0;
      cycle_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 64'd1;
      if (en) timer <= (timer == TIMER_TOP) ? '0 : timer + 1'b1;
      if (startDump) begin
        idx     <= '0;
        pending <= 1'b0;
      end else if (dumping) begin
        if (trigger) begin
          if (pending) dropped <= satInc8(dropped);
          else         pending <= 1'b1;
        end
        if (accept && !isLast) idx <= idx + 1'b1;
      end
    end
  end

  // Shadow captures the pre-update live value in the snapshot cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_EVENTS; i++) begin
        cnt[i]    <= '0;
        shadow[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_EVENTS; i++) begin
        if (clear)   cnt[i] <= '0;
        else if (en) cnt[i] <= cnt[i] + CNT_WIDTH'(inc[i]);
        if (startDump) shadow[i] <= cnt[i];
      end
    end
  end

  assign out_valid = dumping;
  assign busy      = dumping;
  assign out_last  = isLast;
  assign out_id    = dumping ? idx : '0;
  assign out_count = dumping ? shadow[idx] : '0;

endmodule

// File: tb/tb_perf_event_sequencer.sv
// Bench for perf_event_sequencer: directed scenarios plus random traffic,
// all checked against a queue-based behavioural model of the dump stream.
module tb_perf_event_sequencer;

  localparam int NE  = 8;
  localparam int CW  = 32;
  localparam int IV  = 16;
  localparam int IDW = $clog2(NE);

  logic          clk;
  logic          rst;
  logic          en;
  logic [NE-1:0] inc;
  logic          clear;
  logic          dump_req;
  logic          out_valid;
  logic          out_ready;
  logic [IDW-1:0] out_id;
  logic [CW-1:0] out_count;
  logic          out_last;
  logic          busy;
  logic [7:0]    dropped;
  logic [63:0]   cycle_cnt;

  int nTests = 0;
  int nFail  = 0;

  perf_event_sequencer #(.NUM_EVENTS(NE), .CNT_WIDTH(CW), .INTERVAL(IV)) dut (
    .clk(clk), .rst(rst), .en(en), .inc(inc), .clear(clear), .dump_req(dump_req),
    .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id),
    .out_count(out_count), .out_last(out_last), .busy(busy),
    .dropped(dropped), .cycle_cnt(cycle_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [109:0] dutVec;
  assign dutVec = {out_valid, out_id, out_count, out_last, busy, dropped, cycle_cnt};

  // Reference model: live counts, a queue holding the remaining snapshot entries
  logic [CW-1:0] mCnt [NE];
  logic [CW-1:0] mQ [$];
  int            mTimer;
  bit            mPend;
  int            mDrop;
  logic [63:0]   mCyc;

  function automatic void mReset();
    for (int i = 0; i < NE; i++) mCnt[i] = '0;
    mQ.delete();
    mTimer = 0;
    mPend  = 0;
    mDrop  = 0;
    mCyc   = '0;
  endfunction

  function automatic void modelStep();
    bit trig;
    trig = dump_req || (en && mTimer == IV - 1);
    if (mQ.size() == 0) begin
      if (trig || mPend) begin
        for (int i = 0; i < NE; i++) mQ.push_back(mCnt[i]);
        mPend = 0;
      end
    end else begin
      if (trig) begin
        if (mPend) begin
          if (mDrop < 255) mDrop++;
        end else mPend = 1;
      end
      if (out_ready) mQ.delete(0);
    end
    for (int i = 0; i < NE; i++) begin
      if (clear) mCnt[i] = '0;
      else if (en && inc[i]) mCnt[i] = mCnt[i] + 1;
    end
    if (en) mTimer = (mTimer + 1) % IV;
    mCyc = mCyc + 1;
  endfunction

  function automatic logic [109:0] modelVec();
    logic v;
    logic [IDW-1:0] id;
    logic [CW-1:0] c;
    logic l;
    v  = (mQ.size() != 0);
    id = v ? IDW'(NE - mQ.size()) : '0;
    c  = v ? mQ[0] : '0;
    l  = (mQ.size() == 1);
    return {v, id, c, l, v, mDrop[7:0], mCyc};
  endfunction

  task automatic tick();
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic idleInputs();
    en = 0; inc = '0; clear = 0; dump_req = 0; out_ready = 0;
  endtask

  task automatic doReset();
    idleInputs();
    rst = 0;
    mReset();
    @(posedge clk);
    #1;
    rst = 1;
  endtask

  task automatic test_reset();
    idleInputs();
    rst = 1;
    #1 rst = 0;
    #1;
    mReset();
    nTests++;
    if (dutVec !== '0) begin
      nFail++; $display("FAIL reset_outputs: got %h expected 0", dutVec);
    end
    @(posedge clk); #1 rst = 1;
    tick();
    nTests++;
    if (dutVec !== modelVec() || cycle_cnt !== 64'd1) begin
      nFail++; $display("FAIL reset_first_cycle: got %h expected %h", dutVec, modelVec());
    end
  endtask

  task automatic test_basic_dump();
    doReset();
    en = 1;
    inc = NE'(8);
    for (int i = 0; i < 5; i++) tick();
    inc = '0; en = 0;
    dump_req = 1; tick(); dump_req = 0;
    out_ready = 1;
    for (int k = 0; k < NE; k++) begin
      nTests++;
      if (out_valid !== 1'b1 || out_id !== IDW'(k) || out_count !== ((k == 3) ? 32'd5 : 32'd0)
          || out_last !== (k == NE - 1)) begin
        nFail++;
        $display("FAIL basic_entry%0d: valid=%0b id=%0d count=%0d last=%0b, expected id=%0d count=%0d last=%0b",
                 k, out_valid, out_id, out_count, out_last, k, (k == 3) ? 5 : 0, k == NE - 1);
      end
      tick();
    end
    nTests++;
    if (busy !== 1'b0 || dutVec !== modelVec()) begin
      nFail++; $display("FAIL basic_done: busy=%0b got %h expected %h", busy, dutVec, modelVec());
    end
  endtask

  task automatic test_snapshot_edge();
    doReset();
    en = 1; inc = NE'(1);
    for (int i = 0; i < 9; i++) tick();
    dump_req = 1; tick(); dump_req = 0;
    inc = '0; en = 0; out_ready = 1;
    nTests++;
    if (out_id !== '0 || out_count !== 32'd9) begin
      nFail++; $display("FAIL snap_pre_inc: id=%0d count=%0d expected id=0 count=9", out_id, out_count);
    end
    for (int k = 0; k < NE; k++) tick();
    dump_req = 1; tick(); dump_req = 0;
    nTests++;
    if (out_id !== '0 || out_count !== 32'd10 || dutVec !== modelVec()) begin
      nFail++; $display("FAIL snap_next_dump: id=%0d count=%0d expected id=0 count=10", out_id, out_count);
    end
    for (int k = 0; k < NE; k++) tick();
  endtask

  task automatic test_backpressure();
    int order [$];
    int stall;
    logic [CW-1:0] held;
    doReset();
    en = 1;
    for (int i = 0; i < 6; i++) begin
      inc = NE'($urandom);
      tick();
    end
    inc = '0; en = 0;
    dump_req = 1; tick(); dump_req = 0;
    stall = 0; held = '0;
    for (int c = 0; c < 20 && busy; c++) begin
      nTests++;
      if (dutVec !== modelVec()) begin
        nFail++; $display("FAIL bp_model_c%0d: got %h expected %h", c, dutVec, modelVec());
      end
      if (out_id == IDW'(2) && stall < 3) begin
        out_ready = 0;
        if (stall == 0) held = out_count;
        else begin
          nTests++;
          if (out_id !== IDW'(2) || out_count !== held) begin
            nFail++; $display("FAIL bp_hold: id=%0d count=%0d expected id=2 count=%0d", out_id, out_count, held);
          end
        end
        stall++;
      end else out_ready = 1;
      if (out_ready) order.push_back(int'(out_id));
      tick();
    end
    nTests++;
    if (order.size() != NE || busy !== 1'b0) begin
      nFail++; $display("FAIL bp_count: entries=%0d busy=%0b expected entries=%0d busy=0", order.size(), busy, NE);
    end else begin
      for (int i = 0; i < NE; i++) begin
        nTests++;
        if (order[i] != i) begin
          nFail++; $display("FAIL bp_order%0d: got id %0d expected %0d", i, order[i], i);
        end
      end
    end
  endtask

  task automatic test_pending_dropped();
    doReset();
    dump_req = 1; tick();
    out_ready = 0;
    tick();
    tick();
    dump_req = 0;
    nTests++;
    if (dropped !== 8'd1 || out_id !== '0 || out_valid !== 1'b1) begin
      nFail++; $display("FAIL pend_dropped: dropped=%0d id=%0d valid=%0b expected 1/0/1", dropped, out_id, out_valid);
    end
    out_ready = 1;
    for (int k = 0; k < NE; k++) tick();
    nTests++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      nFail++; $display("FAIL pend_gap: busy=%0b valid=%0b expected 0/0", busy, out_valid);
    end
    tick();
    nTests++;
    if (out_valid !== 1'b1 || out_id !== '0 || dutVec !== modelVec()) begin
      nFail++; $display("FAIL pend_extra_start: valid=%0b id=%0d expected 1/0", out_valid, out_id);
    end
    for (int k = 0; k < NE; k++) begin
      dump_req = (k == NE - 1);
      tick();
    end
    dump_req = 0;
    nTests++;
    if (busy !== 1'b0) begin
      nFail++; $display("FAIL last_hs_gap: busy=%0b expected 0", busy);
    end
    tick();
    nTests++;
    if (out_valid !== 1'b1 || out_id !== '0 || dutVec !== modelVec()) begin
      nFail++; $display("FAIL last_hs_followon: valid=%0b id=%0d expected 1/0", out_valid, out_id);
    end
    for (int k = 0; k < NE + 3; k++) tick();
    nTests++;
    if (busy !== 1'b0 || dropped !== 8'd1) begin
      nFail++; $display("FAIL pend_quiet: busy=%0b dropped=%0d expected 0/1", busy, dropped);
    end
  endtask

  task automatic test_auto_interval();
    int rises [$];
    bit prevV;
    logic [63:0] cyc0;
    doReset();
    out_ready = 1;
    prevV = 0; cyc0 = '0;
    for (int t = 1; t <= 60; t++) begin
      en  = !(t >= 35 && t <= 39);
      inc = NE'($urandom);
      tick();
      if (t == 34) cyc0 = cycle_cnt;
      if (t == 39) begin
        nTests++;
        if (cycle_cnt - cyc0 !== 64'd5) begin
          nFail++; $display("FAIL auto_cycle_cnt: advanced %0d expected 5", cycle_cnt - cyc0);
        end
      end
      nTests++;
      if (dutVec !== modelVec()) begin
        nFail++; $display("FAIL auto_model_t%0d: got %h expected %h", t, dutVec, modelVec());
      end
      if (out_valid && out_id == '0 && !prevV) rises.push_back(t);
      prevV = out_valid;
    end
    nTests++;
    if (rises.size() < 3) begin
      nFail++; $display("FAIL auto_rises: got %0d dumps expected at least 3", rises.size());
    end else if (rises[0] != 16 || rises[1] != 32 || rises[2] != 53) begin
      nFail++; $display("FAIL auto_timing: dumps at %0d,%0d,%0d expected 16,32,53", rises[0], rises[1], rises[2]);
    end
    en = 0; inc = '0;
  endtask

  task automatic test_clear_during_dump();
    doReset();
    en = 1; inc = NE'(2);
    for (int i = 0; i < 4; i++) tick();
    dump_req = 1; tick(); dump_req = 0;
    clear = 1; tick(); clear = 0;
    inc = '0; en = 0; out_ready = 1;
    for (int k = 0; k < NE; k++) begin
      if (k == 1) begin
        nTests++;
        if (out_id !== IDW'(1) || out_count !== 32'd4) begin
          nFail++; $display("FAIL clear_shadow: id=%0d count=%0d expected id=1 count=4", out_id, out_count);
        end
      end
      tick();
    end
    dump_req = 1; tick(); dump_req = 0;
    tick();
    nTests++;
    if (out_id !== IDW'(1) || out_count !== 32'd0 || dutVec !== modelVec()) begin
      nFail++; $display("FAIL clear_live: id=%0d count=%0d expected id=1 count=0", out_id, out_count);
    end
    #2 rst = 0;
    #1;
    mReset();
    nTests++;
    if (dutVec !== '0) begin
      nFail++; $display("FAIL async_reset: got %h expected 0", dutVec);
    end
    idleInputs();
    @(posedge clk); #1 rst = 1;
    tick();
    nTests++;
    if (dutVec !== modelVec()) begin
      nFail++; $display("FAIL post_reset: got %h expected %h", dutVec, modelVec());
    end
  endtask

  task automatic test_random();
    doReset();
    for (int c = 0; c < 400; c++) begin
      en        = ($urandom_range(0, 9) < 8);
      inc       = NE'($urandom);
      clear     = ($urandom_range(0, 99) < 3);
      dump_req  = ($urandom_range(0, 99) < 6);
      out_ready = ($urandom_range(0, 9) < 7);
      tick();
      nTests++;
      if (dutVec !== modelVec()) begin
        nFail++; $display("FAIL random_c%0d: got %h expected %h", c, dutVec, modelVec());
      end
    end
    idleInputs();
  endtask

  initial begin
    test_reset();
    test_basic_dump();
    test_snapshot_edge();
    test_backpressure();
    test_pending_dropped();
    test_auto_interval();
    test_clear_during_dump();
    test_random();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
